// File: rtl/enc_pkg.sv
// Shared types and sizing for the request encoder: line count, code width and FSM states.
package enc_pkg;

  localparam int ENC_N = 8;
  localparam int ENC_W = $clog2(ENC_N);

  typedef enum logic {ENC_IDLE, ENC_HOLD} enc_state_t;

  typedef logic [ENC_W-1:0] enc_code_t;

endpackage

// File: rtl/request_encoder8_if.sv
// Request/code handshake bundle between event sources, the encoder and the code consumer.
interface request_encoder8_if
  import enc_pkg::*;
#(
  parameter int N = ENC_N
) ();

  logic [N-1:0]         req;
  logic [$clog2(N)-1:0] code;
  logic                 valid;
  logic                 ack;
  logic [N-1:0]         pending;

  modport master (output req, output ack, input code, input valid, input pending);
  modport slave  (input req, input ack, output code, output valid, output pending);

endinterface

// File: rtl/prio_find.sv
// Combinational search for the first set bit of vec at or after start, wrapping modulo N.
module prio_find #(
  parameter int N = 8
) (
  input  logic [N-1:0]         vec,
  input  logic [$clog2(N)-1:0] start,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int W = $clog2(N);

  logic [W-1:0] pos;

  // Scan farthest offset first so the nearest hit to start is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = start + W'(i);
      if (vec[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/request_encoder8.sv
// Sticky request capture serialised into codes with a valid/ack handshake.
// Define ENC_ROUND_ROBIN_EN for rotating priority; default is fixed priority, index 0 highest.
module request_encoder8
  import enc_pkg::*;
#(
  parameter int N = ENC_N
) (
  input  logic              clk,
  input  logic              rst_n,
  request_encoder8_if.slave bus
);

  localparam int W = $clog2(N);

  enc_state_t   state, next_state;
  logic [N-1:0] pending, clr_mask, cand;
  logic [W-1:0] code, code_next, start, idx;
  logic         valid, valid_next, accept, found;

  assign accept   = valid & bus.ack;
  assign clr_mask = accept ? (N'(1) << code) : '0;
  // A request arriving with its own ack re-sets the bit: set wins over clear.
  assign cand     = (pending & ~clr_mask) | bus.req;

`ifdef ENC_ROUND_ROBIN_EN
  logic [W-1:0] rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= code + 1'b1;
    end
  end

  // Search from the pointer value that takes effect at this same edge.
  assign start = accept ? (code + 1'b1) : rr_ptr;
`else
  assign start = '0;
`endif

  prio_find #(.N(N)) u_find (
    .vec   (cand),
    .start (start),
    .idx   (idx),
    .found (found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ENC_IDLE;
      pending <= '0;
      code    <= '0;
      valid   <= 1'b0;
    end else begin
      state   <= next_state;
      pending <= cand;
      code    <= code_next;
      valid   <= valid_next;
    end
  end

  always_comb begin
    next_state = state;
    code_next  = code;
    valid_next = valid;
    case (state)
      ENC_IDLE: begin
        if (found) begin
          code_next  = idx;
          valid_next = 1'b1;
          next_state = ENC_HOLD;
        end
      end
      ENC_HOLD: begin
        if (bus.ack) begin
          if (found) begin
            code_next = idx;
          end else begin
            valid_next = 1'b0;
            next_state = ENC_IDLE;
          end
        end
      end
      default: begin
        next_state = ENC_IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  assign bus.code    = code;
  assign bus.valid   = valid;
  assign bus.pending = pending;

endmodule
